// File: rtl/pico_ctrl.sv
// pico_ctrl: multi-cycle control unit for a tiny accumulator-style datapath.
// Fetches one instruction per FETCH/EXEC pair and can stall on an external switch handshake.
module pico_ctrl #(
    parameter int IW = 17
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic [IW-1:0] instr,
    input  logic          sw_go,
    output logic [7:0]    pc,
    output logic [1:0]    alu_func,
    output logic          imm_sel,
    output logic          sw_sel,
    output logic          rf_we,
    output logic [2:0]    rd_addr,
    output logic [2:0]    rs_addr,
    output logic [7:0]    imm,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_ADD   = 3'b001,
        OP_ADDI  = 3'b010,
        OP_MULI  = 3'b011,
        OP_MOV   = 3'b100,
        OP_LDSW  = 3'b101,
        OP_WAITH = 3'b110,
        OP_JMP   = 3'b111
    } op_t;

    localparam logic [1:0] ALU_RA   = 2'b00;
    localparam logic [1:0] ALU_RB   = 2'b01;
    localparam logic [1:0] ALU_RADD = 2'b10;
    localparam logic [1:0] ALU_RMUL = 2'b11;

    state_t      state_q;
    logic [7:0]  pc_q;
    logic [16:0] instr_q;
    logic [1:0]  alu_func_q;
    logic        imm_sel_q;
    logic        sw_sel_q;
    logic        rf_we_q;
    logic        busy_q;
    logic        sw_meta_q;
    logic        sw_s_q;

    op_t         fetch_op;
    op_t         exec_op;
    logic [1:0]  alu_func_d;
    logic        imm_sel_d;
    logic        sw_sel_d;
    logic        rf_we_d;

    assign fetch_op = op_t'(instr[16:14]);
    assign exec_op  = op_t'(instr_q[16:14]);

    // Decode the incoming word so the control outputs are registered on entry to EXEC.
    // NOTE: every output of an always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        alu_func_d = ALU_RA;
        imm_sel_d  = 1'b0;
        sw_sel_d   = 1'b0;
        rf_we_d    = 1'b0;
        unique case (fetch_op)
            OP_ADD:  begin alu_func_d = ALU_RADD; rf_we_d = 1'b1; end
            OP_ADDI: begin alu_func_d = ALU_RADD; imm_sel_d = 1'b1; rf_we_d = 1'b1; end
            OP_MULI: begin alu_func_d = ALU_RMUL; imm_sel_d = 1'b1; rf_we_d = 1'b1; end
            OP_MOV:  begin alu_func_d = ALU_RB;   rf_we_d = 1'b1; end
            OP_LDSW: begin alu_func_d = ALU_RA;   sw_sel_d = 1'b1; rf_we_d = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sw_meta_q <= 1'b0;
            sw_s_q    <= 1'b0;
        end else begin
            sw_meta_q <= sw_go;
            sw_s_q    <= sw_meta_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= S_IDLE;
            pc_q       <= 8'h00;
            instr_q    <= '0;
            alu_func_q <= ALU_RA;
            imm_sel_q  <= 1'b0;
            sw_sel_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // Decode outputs live for the single EXEC cycle only.
            alu_func_q <= ALU_RA;
            imm_sel_q  <= 1'b0;
            sw_sel_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            unique case (state_q)
                S_IDLE: state_q <= S_FETCH;
                S_FETCH: begin
                    instr_q    <= instr[16:0];
                    alu_func_q <= alu_func_d;
                    imm_sel_q  <= imm_sel_d;
                    sw_sel_q   <= sw_sel_d;
                    rf_we_q    <= rf_we_d;
                    state_q    <= S_EXEC;
                end
                S_EXEC: begin
                    if (exec_op == OP_WAITH) begin
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT_HI;
                    end else begin
                        pc_q    <= (exec_op == OP_JMP) ? instr_q[7:0] : pc_q + 8'd1;
                        state_q <= S_FETCH;
                    end
                end
                S_WAIT_HI: if (sw_s_q) state_q <= S_WAIT_LO;
                S_WAIT_LO: begin
                    if (!sw_s_q) begin
                        pc_q    <= pc_q + 8'd1;
                        busy_q  <= 1'b0;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pc       = pc_q;
    assign alu_func = alu_func_q;
    assign imm_sel  = imm_sel_q;
    assign sw_sel   = sw_sel_q;
    assign rf_we    = rf_we_q;
    assign busy     = busy_q;
    assign rd_addr  = instr_q[13:11];
    assign rs_addr  = instr_q[10:8];
    assign imm      = instr_q[7:0];

endmodule

// File: tb/tb_pico_ctrl.sv
// Bench for pico_ctrl: program memory model, write-event scoreboard and per-feature scenario tasks.
module tb_pico_ctrl;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [16:0] instr;
    logic        sw_go;
    logic [7:0]  pc;
    logic [1:0]  alu_func;
    logic        imm_sel;
    logic        sw_sel;
    logic        rf_we;
    logic [2:0]  rd_addr;
    logic [2:0]  rs_addr;
    logic [7:0]  imm;
    logic        busy;

    logic [16:0] prog [256];
    logic [26:0] exp_q [$];
    logic [26:0] mon_obs;
    logic [26:0] mon_exp;
    int          n_cmp = 0;
    int          n_err = 0;
    int          decode_err = 0;

    always #5 clk = ~clk;

    assign instr = prog[pc];

    pico_ctrl #(.IW(17)) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .instr    (instr),
        .sw_go    (sw_go),
        .pc       (pc),
        .alu_func (alu_func),
        .imm_sel  (imm_sel),
        .sw_sel   (sw_sel),
        .rf_we    (rf_we),
        .rd_addr  (rd_addr),
        .rs_addr  (rs_addr),
        .imm      (imm),
        .busy     (busy)
    );

    function automatic logic [16:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [7:0] im);
        return {op, rd, rs, im};
    endfunction

    // Write event: {pc, alu_func, imm_sel, sw_sel, rd, rs, imm}
    task automatic expect_write(input logic [7:0] at_pc, input logic [1:0] alu,
                                input logic isel, input logic ssel);
        logic [16:0] w;
        w = prog[at_pc];
        exp_q.push_back({at_pc, alu, isel, ssel, w[13:11], w[10:8], w[7:0]});
    endtask

    // Scoreboard: each observed write cycle pops one expected write.
    always @(negedge clk) begin
        if (n_reset === 1'b1) begin
            if (rf_we === 1'b1) begin
                mon_obs = {pc, alu_func, imm_sel, sw_sel, rd_addr, rs_addr, imm};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL write_unexpected observed=%h required=none", mon_obs);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_obs !== mon_exp) begin
                        n_err++;
                        $display("FAIL write_event observed=%h required=%h", mon_obs, mon_exp);
                    end
                end
            end else if (alu_func !== 2'b00 || imm_sel !== 1'b0 || sw_sel !== 1'b0) begin
                decode_err++;
                $display("FAIL decode_default pc=%h alu_func=%b imm_sel=%b sw_sel=%b required=00/0/0",
                         pc, alu_func, imm_sel, sw_sel);
            end
        end
    end

    task automatic hold_reset();
        @(negedge clk);
        n_reset = 1'b0;
        sw_go   = 1'b0;
        for (int i = 0; i < 256; i++) prog[i] = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        hold_reset();
        n_cmp++;
        if ({pc, alu_func, imm_sel, sw_sel, rf_we, busy, rd_addr, rs_addr, imm} !== '0) begin
            n_err++;
            $display("FAIL reset_state observed pc=%h alu=%b isel=%b ssel=%b we=%b busy=%b rd=%h rs=%h imm=%h required all zero",
                     pc, alu_func, imm_sel, sw_sel, rf_we, busy, rd_addr, rs_addr, imm);
        end
        release_reset();
        @(negedge clk);
        n_cmp++;
        if ({pc, rf_we, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_release observed pc=%h we=%b busy=%b required 00/0/0", pc, rf_we, busy);
        end
    endtask

    task automatic test_nop();
        hold_reset();
        release_reset();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (pc !== 8'((k - 1) / 2)) begin
                n_err++;
                $display("FAIL nop_pc k=%0d observed=%h required=%h", k, pc, 8'((k - 1) / 2));
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL nop_missing observed_pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_addi();
        hold_reset();
        prog[0] = mk(3'b010, 3'd3, 3'd0, 8'h05);
        expect_write(8'h00, 2'b10, 1'b1, 1'b0);
        release_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({rd_addr, imm} !== {3'd3, 8'h05}) begin
            n_err++;
            $display("FAIL addi_fields observed rd=%h imm=%h required rd=3 imm=05", rd_addr, imm);
        end
        @(negedge clk);
        n_cmp++;
        if (pc !== 8'h01) begin
            n_err++;
            $display("FAIL addi_pc observed=%h required=01", pc);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL addi_missing observed_pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_alu_ops();
        hold_reset();
        prog[0] = mk(3'b011, 3'd1, 3'd0, 8'h40);
        prog[1] = mk(3'b101, 3'd2, 3'd0, 8'h00);
        prog[2] = mk(3'b001, 3'd4, 3'd5, 8'h11);
        prog[3] = mk(3'b100, 3'd6, 3'd7, 8'h9A);
        expect_write(8'h00, 2'b11, 1'b1, 1'b0);
        expect_write(8'h01, 2'b00, 1'b0, 1'b1);
        expect_write(8'h02, 2'b10, 1'b0, 1'b0);
        expect_write(8'h03, 2'b01, 1'b0, 1'b0);
        release_reset();
        repeat (12) @(negedge clk);
        n_cmp++;
        if (pc !== 8'h05) begin
            n_err++;
            $display("FAIL alu_ops_pc observed=%h required=05", pc);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL alu_ops_missing observed_pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_wait();
        bit found;
        bit bad;
        int n;
        hold_reset();
        prog[4] = mk(3'b110, 3'd0, 3'd0, 8'h00);
        prog[6] = mk(3'b110, 3'd0, 3'd0, 8'h00);
        release_reset();
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (busy === 1'b1) found = 1;
        end
        n_cmp++;
        if (!found || pc !== 8'h04) begin
            n_err++;
            $display("FAIL wait_entry observed busy_seen=%0d pc=%h required 1/04", found, pc);
        end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b1 || pc !== 8'h04) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL wait_hold_low observed pc=%h busy=%b required 04/1", pc, busy);
        end
        sw_go = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy !== 1'b1 || pc !== 8'h04) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL wait_hold_high observed pc=%h busy=%b required 04/1", pc, busy);
        end
        sw_go = 1'b0;
        n = 0;
        found = 0;
        for (int i = 1; i <= 8 && !found; i++) begin
            @(negedge clk);
            if (pc === 8'h05) begin found = 1; n = i; end
        end
        n_cmp++;
        if (!found || n < 2 || n > 3 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL wait_release observed cycles=%0d busy=%b required 2..3/0", n, busy);
        end
        // Switch already high before the second WAITH executes.
        sw_go = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (busy === 1'b1) found = 1;
        end
        n_cmp++;
        if (!found || pc !== 8'h06) begin
            n_err++;
            $display("FAIL wait_pre_high_entry observed busy_seen=%0d pc=%h required 1/06", found, pc);
        end
        repeat (3) @(negedge clk);
        sw_go = 1'b0;
        n = 0;
        found = 0;
        for (int i = 1; i <= 8 && !found; i++) begin
            @(negedge clk);
            if (pc === 8'h07) begin found = 1; n = i; end
        end
        n_cmp++;
        if (!found || n > 3) begin
            n_err++;
            $display("FAIL wait_pre_high_release observed cycles=%0d required 1..3", n);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL wait_missing observed_pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_jmp();
        bit bad;
        hold_reset();
        prog[0] = mk(3'b111, 3'd0, 3'd0, 8'hFF);
        release_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pc !== 8'hFF) begin
            n_err++;
            $display("FAIL jmp_target observed=%h required=ff", pc);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (pc !== 8'h00) begin
            n_err++;
            $display("FAIL jmp_wrap observed=%h required=00", pc);
        end
        hold_reset();
        prog[2] = mk(3'b111, 3'd0, 3'd0, 8'h02);
        release_reset();
        repeat (4) @(negedge clk);
        bad = 0;
        repeat (26) begin
            @(negedge clk);
            if (pc !== 8'h02) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL jmp_self observed=%h required=02", pc);
        end
    endtask

    task automatic test_reset_abort();
        bit found;
        hold_reset();
        prog[0] = mk(3'b001, 3'd1, 3'd2, 8'h00);
        release_reset();
        @(posedge clk);
        @(posedge clk);
        #1 n_reset = 1'b0;
        #1;
        n_cmp++;
        if ({pc, alu_func, imm_sel, sw_sel, rf_we, busy} !== '0) begin
            n_err++;
            $display("FAIL abort_exec observed pc=%h alu=%b isel=%b ssel=%b we=%b busy=%b required zero",
                     pc, alu_func, imm_sel, sw_sel, rf_we, busy);
        end
        expect_write(8'h00, 2'b10, 1'b0, 1'b0);
        release_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (pc !== 8'h00) begin
            n_err++;
            $display("FAIL abort_restart observed=%h required=00", pc);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL abort_missing observed_pending=%0d required=0", exp_q.size());
        end

        hold_reset();
        prog[0] = mk(3'b110, 3'd0, 3'd0, 8'h00);
        sw_go   = 1'b1;
        release_reset();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (busy === 1'b1) found = 1;
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 n_reset = 1'b0;
        #1;
        n_cmp++;
        if (!found || {pc, busy, rf_we, alu_func} !== '0) begin
            n_err++;
            $display("FAIL abort_wait observed busy_seen=%0d pc=%h busy=%b we=%b alu=%b required 1/00/0/0/00",
                     found, pc, busy, rf_we, alu_func);
        end
        sw_go = 1'b0;
        release_reset();
        @(negedge clk);
        n_cmp++;
        if ({pc, busy} !== '0) begin
            n_err++;
            $display("FAIL abort_wait_restart observed pc=%h busy=%b required 00/0", pc, busy);
        end
    endtask

    task automatic test_defaults();
        n_cmp++;
        if (decode_err !== 0) begin
            n_err++;
            $display("FAIL decode_outside_exec observed=%0d required=0", decode_err);
        end
    endtask

    initial begin
        n_reset = 1'b0;
        sw_go   = 1'b0;
        for (int i = 0; i < 256; i++) prog[i] = '0;
        test_reset();
        test_nop();
        test_addi();
        test_alu_ops();
        test_wait();
        test_jmp();
        test_reset_abort();
        test_defaults();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pico_ctrl.md
PICO_CTRL -- requirements
Module: pico_ctrl

Interface
REQ-001 Parameter: IW, default 17, instruction width; fields are op=[16:14], rd=[13:11], rs=[10:8], imm=[7:0].
REQ-002 Ports (one per line):
- clk  in  1  system clock; all state changes on rising edge.
- n_reset  in  1  asynchronous active-low reset.
- instr  in  IW  instruction at address pc from program memory, valid combinationally.
- sw_go  in  1  asynchronous user handshake switch.
- pc  out  8  program counter / program memory address.
- alu_func  out  2  ALU operation select: RA=00, RB=01, RADD=10, R_mul=11.
- imm_sel  out  1  1 = ALU b operand from imm.
- sw_sel  out  1  1 = ALU a operand from switches.
- rf_we  out  1  register file write enable, writes ALU result to rd_addr.
- rd_addr  out  3  destination / a-operand register.
- rs_addr  out  3  source / b-operand register.
- imm  out  8  immediate field of the captured instruction.
- busy  out  1  high while in WAIT_HI or WAIT_LO.

Function
REQ-003 FSM states: IDLE, FETCH, EXEC, WAIT_HI, WAIT_LO.
REQ-004 IDLE -> FETCH unconditionally, so the first fetch occurs 1 cycle after reset deassertion.
REQ-005 FETCH: captures instr into instr_q on the clock edge, then goes to EXEC; pc is held.
REQ-006 EXEC decodes instr_q as follows.
- 000 NOP: no write.
- 001 ADD: RADD, rf_we=1.
- 010 ADDI: RADD, imm_sel=1, rf_we=1.
- 011 MULI: R_mul, imm_sel=1, rf_we=1.
- 100 MOV: RB, rf_we=1.
- 101 LDSW: RA, sw_sel=1, rf_we=1.
- 110 WAITH: goes to WAIT_HI, no write.
- 111 JMP: pc <= imm, no write.
REQ-007 Outside EXEC, all decode outputs are at their defaults: alu_func=00, imm_sel=0, sw_sel=0, rf_we=0.
- rd_addr, rs_addr and imm always reflect instr_q.
REQ-008 rf_we is high for exactly one cycle per writing instruction.
REQ-009 On leaving EXEC for opcodes other than JMP and WAITH, pc <= pc+1, then FETCH.
- Non-wait instructions take exactly 2 cycles.
REQ-010 pc is 8-bit modulo: 255+1 wraps to 0; JMP to its own address loops indefinitely.
REQ-011 sw_go passes through a 2-flop synchronizer (sw_s) before use; this adds 2 cycles of latency.
REQ-012 WAIT_HI stays until sw_s=1, then goes to WAIT_LO.
- WAIT_LO stays until sw_s=0, then pc <= pc+1 and FETCH.
- A sw_go level already high at WAITH entry satisfies WAIT_HI immediately.
REQ-013 busy=1 exactly in WAIT_HI and WAIT_LO.
REQ-014 sw_go pulses shorter than 2 clk periods need not be detected.
- sw_go activity outside the wait states is ignored.
REQ-015 The block contains no arithmetic other than the pc increment; the MULI result scaling (product bits [14:7]) belongs to the ALU.

Reset
REQ-016 While n_reset=0, independent of clk, the following hold:
- state=IDLE, pc=0, instr_q=0, synchronizer flops=0.
- rf_we=0, alu_func=00, imm_sel=0, sw_sel=0, busy=0.
REQ-017 Reset asserted mid-instruction (including EXEC or a wait state) aborts it with no rf_we pulse.
- After release, execution restarts at pc=0 via IDLE.
REQ-018 No output may glitch high at reset release.

Verification
REQ-019 Reset release, program of NOPs -> pc=0 for 2 cycles, then increments every 2 cycles; rf_we stays 0.
REQ-020 ADDI rd=3, imm=0x05 at pc=0 -> one EXEC cycle shows alu_func=10, imm_sel=1, rf_we=1, rd_addr=3, imm=0x05; then pc=1.
REQ-021 MULI imm=0x40, then LDSW -> first shows alu_func=11 with imm_sel=1; second shows alu_func=00 with sw_sel=1; each has a 1-cycle rf_we.
REQ-022 WAITH at pc=4, sw_go low for 10 cycles, high for 5, then low -> the following required responses:
- busy=1 throughout the wait; pc stays 4.
- pc=5 occurs 2-3 cycles after sw_go falls.
- A 1-cycle sw_go pulse is not required to register.
REQ-023 JMP imm=0xFF, then a NOP at 0xFF -> pc=0xFF, then wraps to 0x00.
- Separately, JMP to self holds pc constant indefinitely.
REQ-024 n_reset pulsed low during EXEC of ADD and during WAIT_LO -> pc=0 and outputs at defaults immediately (asynchronously); no rf_we pulse; restarts from IDLE.
